// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder between the UART RX FIFO and TX FIFO: optional echo,
// single-letter command pulses, "S" + two hex digits loads set_val, '?' on bad input.
module uart_cmd_decoder #(
    parameter bit         ECHO_EN  = 1'b1,
    parameter logic [7:0] ERR_CHAR = 8'h3F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_empty,
    input  logic [7:0] rx_pop_data,
    output logic       rx_pop,
    input  logic       tx_full,
    output logic       tx_push,
    output logic [7:0] tx_push_data,
    output logic       cmd_run,
    output logic       cmd_clear,
    output logic       cmd_mode,
    output logic [7:0] set_val,
    output logic       set_valid,
    output logic       set_pending
);

    typedef enum logic [1:0] {IDLE, ECHO, DECODE, ERR} state_t;

    state_t     state_q, state_d;
    logic [7:0] ch_q, ch_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] set_val_q, set_val_d;
    logic       digit_q, digit_d;
    logic       pend_q, pend_d;
    logic       run_q, run_d;
    logic       clr_q, clr_d;
    logic       mode_q, mode_d;
    logic       sv_q, sv_d;

    logic       is_hex;
    logic [3:0] nib;
    logic [7:0] lc;
    logic       pop_c;

    // Letters differ from their upper case only in bit 5.
    assign lc = ch_q | 8'h20;

    always_comb begin
        is_hex = 1'b0;
        nib    = 4'h0;
        if (ch_q >= 8'h30 && ch_q <= 8'h39) begin
            is_hex = 1'b1;
            nib    = ch_q[3:0];
        end else if ((ch_q >= 8'h41 && ch_q <= 8'h46) ||
                     (ch_q >= 8'h61 && ch_q <= 8'h66)) begin
            is_hex = 1'b1;
            nib    = ch_q[3:0] + 4'd9;
        end
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        shadow_d     = shadow_q;
        set_val_d    = set_val_q;
        digit_d      = digit_q;
        pend_d       = pend_q;
        run_d        = 1'b0;
        clr_d        = 1'b0;
        mode_d       = 1'b0;
        sv_d         = 1'b0;
        pop_c        = 1'b0;
        tx_push      = 1'b0;
        tx_push_data = 8'h00;

        case (state_q)
            IDLE: begin
                if (!rx_empty) begin
                    pop_c   = 1'b1;
                    ch_d    = rx_pop_data;
                    state_d = ECHO_EN ? ECHO : DECODE;
                end
            end
            ECHO: begin
                if (!tx_full) begin
                    tx_push      = 1'b1;
                    tx_push_data = ch_q;
                    state_d      = DECODE;
                end
            end
            DECODE: begin
                state_d = IDLE;
                if (pend_q) begin
                    if (is_hex && !digit_q) begin
                        shadow_d = {shadow_q[3:0], nib};
                        digit_d  = 1'b1;
                    end else if (is_hex) begin
                        set_val_d = {shadow_q[3:0], nib};
                        sv_d      = 1'b1;
                        pend_d    = 1'b0;
                        digit_d   = 1'b0;
                    end else begin
                        pend_d   = 1'b0;
                        digit_d  = 1'b0;
                        shadow_d = 8'h00;
                        state_d  = ERR;
                    end
                end else if (ch_q == 8'h0D || ch_q == 8'h0A) begin
                    state_d = IDLE;
                end else if (lc == 8'h72) begin
                    run_d = 1'b1;
                end else if (lc == 8'h63) begin
                    clr_d = 1'b1;
                end else if (lc == 8'h6D) begin
                    mode_d = 1'b1;
                end else if (lc == 8'h73) begin
                    pend_d   = 1'b1;
                    digit_d  = 1'b0;
                    shadow_d = 8'h00;
                end else begin
                    state_d = ERR;
                end
            end
            ERR: begin
                if (!tx_full) begin
                    tx_push      = 1'b1;
                    tx_push_data = ERR_CHAR;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The pop strobe is combinational from IDLE, so gate it while reset is held.
    assign rx_pop = pop_c & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ch_q      <= 8'h00;
            shadow_q  <= 8'h00;
            set_val_q <= 8'h00;
            digit_q   <= 1'b0;
            pend_q    <= 1'b0;
            run_q     <= 1'b0;
            clr_q     <= 1'b0;
            mode_q    <= 1'b0;
            sv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            shadow_q  <= shadow_d;
            set_val_q <= set_val_d;
            digit_q   <= digit_d;
            pend_q    <= pend_d;
            run_q     <= run_d;
            clr_q     <= clr_d;
            mode_q    <= mode_d;
            sv_q      <= sv_d;
        end
    end

    assign cmd_run     = run_q;
    assign cmd_clear   = clr_q;
    assign cmd_mode    = mode_q;
    assign set_val     = set_val_q;
    assign set_valid   = sv_q;
    assign set_pending = pend_q;

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Command decoder sitting directly downstream of the UART controller's RX FIFO and upstream of its TX FIFO. It pops received ASCII bytes one at a time and optionally echoes each one back through the TX FIFO. Single-character commands become one-cycle control pulses for the application datapath, and `S` plus two hex digits loads an 8-bit set value. Invalid input produces an error character on TX.

## Interface
- `ECHO_EN`, default 1: 1 = every popped byte is pushed back to TX before decode; 0 = no echo.
- `ERR_CHAR`, default 8'h3F (`?`): byte pushed to TX on an unknown command or an aborted hex entry.

- `clk`  in  1  single system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_empty`  in  1  RX FIFO empty flag.
- `rx_pop_data`  in  8  RX FIFO head byte; valid whenever `rx_empty`=0.
- `rx_pop`  out  1  one-cycle pop strobe to RX FIFO.
- `tx_full`  in  1  TX FIFO full flag.
- `tx_push`  out  1  one-cycle push strobe to TX FIFO.
- `tx_push_data`  out  8  byte to push; valid when `tx_push`=1.
- `cmd_run`  out  1  pulse on `r`/`R`.
- `cmd_clear`  out  1  pulse on `c`/`C`.
- `cmd_mode`  out  1  pulse on `m`/`M`.
- `set_val`  out  8  last completed hex value.
- `set_valid`  out  1  pulse when `set_val` is updated.
- `set_pending`  out  1  high while a hex entry is in progress.

## Operation
- FSM states: IDLE, ECHO, DECODE, ERR.
- **IDLE**
  - If `rx_empty`=0: assert `rx_pop` combinationally for exactly this cycle and latch `rx_pop_data` into `ch`.
  - Next state is ECHO (`ECHO_EN`=1) or DECODE (`ECHO_EN`=0).
  - If `rx_empty`=1: stay; `rx_pop`=0.
- **ECHO**
  - If `tx_full`=0: `tx_push`=1 with `tx_push_data`=`ch`, then go to DECODE.
  - Otherwise hold with `tx_push`=0. No further RX pops occur while stalled.
- **DECODE, normal mode** (`set_pending`=0)
  - `r`/`R`, `c`/`C`, `m`/`M`: set the matching cmd pulse register, then go to IDLE.
  - `s`/`S`: set `set_pending`, clear the digit counter and shadow, then go to IDLE.
  - 0x0D and 0x0A: no action, no error; go to IDLE.
  - Any other byte: go to ERR.
- **DECODE, hex mode** (`set_pending`=1)
  - Accepted digits: `0`-`9`, `a`-`f`, `A`-`F`. Each digit is shifted into the shadow, high nibble first.
  - First digit: go to IDLE.
  - Second digit: `set_val` <= shadow, `set_valid` pulse, clear `set_pending`, go to IDLE.
  - Any non-hex byte, including CR/LF and command letters: clear `set_pending`, discard the shadow, leave `set_val` unchanged, go to ERR.
- **ERR**
  - When `tx_full`=0: `tx_push`=1 with `tx_push_data`=`ERR_CHAR`, then go to IDLE.
  - Otherwise hold.
- Output pulses: `cmd_*` and `set_valid` are registered, high for exactly one cycle, and mutually exclusive.
- Stall behaviour: `tx_full` never drops a byte. The block stalls, and backpressure propagates into the RX FIFO.
- Reset: `rst` mid-operation, in any state including mid-hex entry, returns to IDLE immediately. A partial hex entry is lost.

## Timing
- Reset values:
  - `rx_pop`=0, `tx_push`=0, `tx_push_data`=8'h00.
  - all `cmd_*`=0, `set_valid`=0, `set_pending`=0, `set_val`=8'h00.
  - state = IDLE.
- Byte visible in IDLE at cycle t: `rx_pop` is high at t.
- With `ECHO_EN`=1 and TX not full:
  - echo `tx_push` at t+1;
  - DECODE at t+2;
  - cmd/`set_valid` pulse high at t+3;
  - IDLE again at t+3, so the next pop is at t+3 at the earliest. Throughput is 1 byte per 3 cycles.
- With `ECHO_EN`=0: DECODE at t+1, pulse at t+2, next pop at t+2 at the earliest.
- Error path: the `ERR_CHAR` push occurs one cycle after DECODE (t+3 with echo), and the next pop is at t+4 at the earliest.
- Each cycle `tx_full`=1 in ECHO or ERR adds exactly one cycle of latency.
- `set_pending` rises in the cycle after DECODE of `S`. It falls in the same cycle that `set_valid` is high, or when ERR is entered.
- `rx_pop` is never asserted while `rx_empty`=1. `tx_push` is never asserted while `tx_full`=1.

## Test plan
- `ECHO_EN`=1, RX supplies `r`, TX never full -> echo push of 8'h72 at t+1; `cmd_run` high exactly one cycle at t+3; no other pulse.
- RX supplies `S`,`3`,`f` -> three echoes (8'h53, 8'h33, 8'h66); `set_pending` high from the `S` decode until the `f` decode; `set_val`=8'h3F with `set_valid` one-cycle pulse.
- RX supplies `S`,`1`,`x` -> echoes of all three bytes, then push of 8'h3F; `set_val` keeps its previous value; `set_pending`=0; no `set_valid`.
- RX supplies `z` then `c` -> echo of `z`, then 8'h3F push, then echo of `c` and a `cmd_clear` pulse; push order on TX is `z`,`?`,`c`.
- `tx_full` held high for 5 cycles during ECHO of `m` -> `tx_push`=0 and no `rx_pop` for those cycles; echo occurs on the first cycle with `tx_full`=0; `cmd_mode` pulse delayed by 5 cycles; no byte lost.
- `rst` asserted after `S`,`A` -> all outputs at reset values immediately; after release, RX `5` yields echo plus 8'h3F (treated as unknown command); `set_val` remains 8'h00.
